// File: rtl/computer_pkg.sv
// Shared definitions for the program loader: core select codes, FSM encoding
// and RAM sizing.
package computer_pkg;

  localparam logic [3:0] SEL_PC  = 4'h0;
  localparam logic [3:0] SEL_MAR = 4'h1;
  localparam logic [3:0] SEL_RAM = 4'h2;

  localparam int CORE_ADDR_W = 4;
  localparam int MAX_LEN     = 2**CORE_ADDR_W;

  // state       | meaning
  // S_IDLE      | no session; core_HLT keeps its last value
  // S_HALT      | hold core in reset/halt, select PC
  // S_WAIT_BYTE | host_ready high, waiting for the next program byte
  // S_SET_ADDR  | load MAR with the write address
  // S_WRITE     | write latched byte into core RAM
  // S_VADDR     | load MAR with the read-back address
  // S_VREAD     | drive RAM onto the bus and compare on the hold cycle
  // S_RELEASE   | final reset pulse, then release core if no error
  typedef enum logic [2:0] {
    S_IDLE, S_HALT, S_WAIT_BYTE, S_SET_ADDR,
    S_WRITE, S_VADDR, S_VREAD, S_RELEASE
  } state_t;

  // Every state except IDLE and WAIT_BYTE runs exactly one strobe phase.
  function automatic logic is_strobe_state(input state_t s);
    return !((s == S_IDLE) || (s == S_WAIT_BYTE));
  endfunction

endpackage

// File: rtl/strobe_phase.sv
// Setup / go / hold timer for one core strobe. start_phase is held high for
// the whole strobe state; a fresh phase restarts automatically after each hold
// cycle so back-to-back strobe states need no idle gap.
module strobe_phase #(
  parameter int GO_CYCLES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic start_phase,
  output logic go,
  output logic phase_done
);

  localparam logic [3:0] LOAD = 4'(GO_CYCLES + 1);

  logic [3:0] cnt;

  // Down-counter: LOAD = setup, GO_CYCLES..1 = go high, 0 = hold.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= LOAD;
    end else if (!start_phase || (cnt == 4'd0)) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end

  // go is decoded from the counter so an async reset drops it immediately.
  always_comb begin
    go         = start_phase && (cnt != 4'd0) && (cnt != LOAD);
    phase_done = start_phase && (cnt == 4'd0);
  end

endmodule

// File: rtl/program_loader.sv
// Host-side programmer: streams bytes into the 8-bit core's RAM through its
// programming port, optionally reads them back, then releases the core.
module program_loader
  import computer_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int GO_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  input  logic              verify,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [3:0]        core_sel,
  output logic [DATA_W-1:0] core_in,
  output logic              core_go,
  output logic              core_en,
  output logic              core_OE,
  output logic              core_WE,
  output logic              core_load,
  output logic              core_HLT,
  output logic              core_RESET,
  input  logic [DATA_W-1:0] core_bus,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int DEPTH = 2**ADDR_W;

  state_t              state, state_nxt;
  logic [ADDR_W:0]     addr;
  logic [ADDR_W:0]     len_q;
  logic                verify_q;
  logic [DATA_W-1:0]   byte_q;
  logic                error_q;
  logic [ADDR_W-1:0]   err_addr_q;
  logic                hlt_q;
  logic                done_q;
  logic [DATA_W-1:0]   shadow [DEPTH];
  logic                phase_done;
  logic                len_bad;
  logic                last_addr;

  assign len_bad   = (length == '0) || (length > (ADDR_W+1)'(DEPTH));
  assign last_addr = (addr == (len_q - 1'b1));

  strobe_phase #(.GO_CYCLES(GO_CYCLES)) u_phase (
    .CLK        (CLK),
    .RESET      (RESET),
    .start_phase(is_strobe_state(state)),
    .go         (core_go),
    .phase_done (phase_done)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and per-state core controls; controls are constant for the
  // whole state, so they only move at setup or after hold.
  always_comb begin
    state_nxt  = state;
    host_ready = 1'b0;
    core_sel   = SEL_PC;
    core_in    = '0;
    core_load  = 1'b0;
    core_WE    = 1'b0;
    core_OE    = 1'b0;
    core_RESET = 1'b0;
    case (state)
      S_IDLE: if (start && !len_bad) state_nxt = S_HALT;
      S_HALT: begin
        core_RESET = 1'b1;
        if (phase_done) state_nxt = S_WAIT_BYTE;
      end
      S_WAIT_BYTE: begin
        host_ready = 1'b1;
        if (host_valid) state_nxt = S_SET_ADDR;
      end
      S_SET_ADDR, S_VADDR: begin
        core_sel  = SEL_MAR;
        core_in   = DATA_W'(addr[ADDR_W-1:0]);
        core_load = 1'b1;
        if (phase_done) state_nxt = (state == S_SET_ADDR) ? S_WRITE : S_VREAD;
      end
      S_WRITE: begin
        core_sel = SEL_RAM;
        core_in  = byte_q;
        core_WE  = 1'b1;
        if (phase_done) begin
          if (last_addr) state_nxt = verify_q ? S_VADDR : S_RELEASE;
          else           state_nxt = S_WAIT_BYTE;
        end
      end
      S_VREAD: begin
        core_sel = SEL_RAM;
        core_OE  = 1'b1;
        if (phase_done) state_nxt = last_addr ? S_RELEASE : S_VADDR;
      end
      S_RELEASE: begin
        core_RESET = 1'b1;
        if (phase_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Session datapath: latched request, address counter, error and release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr       <= '0;
      len_q      <= '0;
      verify_q   <= 1'b0;
      byte_q     <= '0;
      error_q    <= 1'b0;
      err_addr_q <= '0;
      hlt_q      <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len_bad) begin
              error_q    <= 1'b1;
              err_addr_q <= '0;
            end else begin
              error_q  <= 1'b0;
              len_q    <= length;
              verify_q <= verify;
              addr     <= '0;
              hlt_q    <= 1'b1;
            end
          end
        end
        S_WAIT_BYTE: if (host_valid) byte_q <= host_data;
        S_WRITE: begin
          if (phase_done) begin
            if (last_addr) addr <= '0;
            else           addr <= addr + 1'b1;
          end
        end
        S_VREAD: begin
          if (phase_done) begin
            if ((core_bus != shadow[addr[ADDR_W-1:0]]) && !error_q) begin
              error_q    <= 1'b1;
              err_addr_q <= addr[ADDR_W-1:0];
            end
            if (!last_addr) addr <= addr + 1'b1;
          end
        end
        S_RELEASE: begin
          if (phase_done) begin
            hlt_q  <= error_q;
            done_q <= !error_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Shadow copy of every written byte for the read-back compare.
  always_ff @(posedge CLK) begin
    if ((state == S_WRITE) && phase_done) shadow[addr[ADDR_W-1:0]] <= byte_q;
  end

  assign core_en  = 1'b0;
  assign core_HLT = hlt_q;
  assign busy     = (state != S_IDLE);
  assign done     = done_q;
  assign error    = error_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a small core model (MAR + 16-byte RAM).
module tb_program_loader;
  import computer_pkg::*;

  localparam int GO_CYC = 2;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       start = 1'b0, verify = 1'b0;
  logic [4:0] length = '0;
  logic [7:0] host_data = '0;
  logic       host_valid = 1'b0;
  logic       host_ready;
  logic [3:0] core_sel;
  logic [7:0] core_in;
  logic       core_go, core_en, core_OE, core_WE, core_load, core_HLT, core_RESET;
  logic [7:0] core_bus;
  logic       busy, done, error;
  logic [3:0] err_addr;

  int checks = 0;
  int errors = 0;

  // core model and monitor state
  logic [3:0] mar = '0;
  logic [7:0] ram [16];
  logic       corrupt = 1'b0;
  logic [7:0] mar_log [32];
  logic [7:0] wd_log  [32];
  int mar_n = 0, wd_n = 0, oe_n = 0, phases = 0, done_n = 0;
  int go_run = 0, bad_go = 0, illegal = 0, hr_bad = 0;
  logic go_prev = 1'b0;

  program_loader #(.DATA_W(8), .ADDR_W(4), .GO_CYCLES(GO_CYC)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .verify(verify), .length(length),
    .host_data(host_data), .host_valid(host_valid), .host_ready(host_ready),
    .core_sel(core_sel), .core_in(core_in), .core_go(core_go), .core_en(core_en),
    .core_OE(core_OE), .core_WE(core_WE), .core_load(core_load),
    .core_HLT(core_HLT), .core_RESET(core_RESET), .core_bus(core_bus),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr)
  );

  always #5 CLK = ~CLK;

  // core: MAR load and RAM write on go
  always @(posedge CLK) begin
    if (core_go && core_sel == SEL_MAR && core_load) mar <= core_in[3:0];
    if (core_go && core_sel == SEL_RAM && core_WE)   ram[mar] <= core_in;
  end

  always_comb begin
    core_bus = 8'h00;
    if (core_sel == SEL_RAM && core_OE)
      core_bus = (corrupt && (mar == 4'd1 || mar == 4'd2)) ? 8'h00 : ram[mar];
  end

  // monitor: phase lengths, logged strobes, rule violations
  always @(negedge CLK) begin
    if (!RESET) begin
      go_run  = 0;
      go_prev = 1'b0;
    end else begin
      if (core_go && !go_prev) begin
        if (core_sel == SEL_MAR && core_load) begin mar_log[mar_n] = core_in; mar_n++; end
        if (core_sel == SEL_RAM && core_WE)   begin wd_log[wd_n]   = core_in; wd_n++;  end
        if (core_sel == SEL_RAM && core_OE)   oe_n++;
      end
      if (core_go) go_run++;
      else if (go_run != 0) begin
        if (go_run != GO_CYC) bad_go++;
        phases++;
        go_run = 0;
      end
      go_prev = core_go;
      if (done) done_n++;
      if ((core_WE && core_OE) || (core_WE && core_load)) illegal++;
      if (host_ready && (core_go || core_WE || core_OE || core_load || core_RESET)) hr_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    mar_n = 0; wd_n = 0; oe_n = 0; phases = 0; done_n = 0;
  endtask

  task automatic do_start(input logic [4:0] l, input logic v);
    @(negedge CLK);
    start = 1'b1; length = l; verify = v;
    @(negedge CLK);
    start = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int delay);
    logic ok;
    ok = 1'b0;
    repeat (delay) @(negedge CLK);
    host_data = b; host_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (host_ready) begin
        @(posedge CLK); #1;
        host_valid = 1'b0;
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    host_valid = 1'b0;
    check("byte_accept", ok, 1);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
    @(negedge CLK); #1;
  endtask

  initial begin
    logic ok;
    int wd_save;
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK); #1;

    // reset state
    check("rst_busy", busy, 0);
    check("rst_ready", host_ready, 0);
    check("rst_hlt", core_HLT, 1);
    check("rst_go", core_go, 0);
    check("rst_error", error, 0);
    check("rst_done", done, 0);
    check("rst_core_reset", core_RESET, 0);
    check("rst_en", core_en, 0);

    // 1: three bytes, no verify
    clr();
    do_start(5'd3, 1'b0);
    check("t1_busy", busy, 1);
    check("t1_halt_reset", core_RESET, 1);
    check("t1_hlt_held", core_HLT, 1);
    send_byte(8'hA0, 0);
    send_byte(8'h1F, 0);
    send_byte(8'h2E, 0);
    wait_idle();
    check("t1_mar_n", mar_n, 3);
    check("t1_mar0", mar_log[0], 8'h00);
    check("t1_mar1", mar_log[1], 8'h01);
    check("t1_mar2", mar_log[2], 8'h02);
    check("t1_wd_n", wd_n, 3);
    check("t1_wd0", wd_log[0], 8'hA0);
    check("t1_wd1", wd_log[1], 8'h1F);
    check("t1_wd2", wd_log[2], 8'h2E);
    check("t1_ram1", ram[1], 8'h1F);
    check("t1_oe_n", oe_n, 0);
    check("t1_done_n", done_n, 1);
    check("t1_hlt", core_HLT, 0);
    check("t1_error", error, 0);

    // 2: verify with faithful RAM
    clr();
    do_start(5'd2, 1'b1);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    wait_idle();
    check("t2_oe_n", oe_n, 2);
    check("t2_phases", phases, 10);
    check("t2_error", error, 0);
    check("t2_done_n", done_n, 1);
    check("t2_hlt", core_HLT, 0);

    // 3: verify with RAM corrupting addresses 1 and 2
    clr();
    corrupt = 1'b1;
    do_start(5'd3, 1'b1);
    send_byte(8'h11, 0);
    send_byte(8'h55, 0);
    send_byte(8'h77, 0);
    wait_idle();
    corrupt = 1'b0;
    check("t3_oe_n", oe_n, 3);
    check("t3_error", error, 1);
    check("t3_err_addr", err_addr, 1);
    check("t3_done_n", done_n, 0);
    check("t3_hlt", core_HLT, 1);

    // 4: bad lengths, then a clean session clears error
    clr();
    do_start(5'd0, 1'b0);
    check("t4_len0_error", error, 1);
    check("t4_len0_err_addr", err_addr, 0);
    check("t4_len0_busy", busy, 0);
    do_start(5'd1, 1'b0);
    check("t4_clear_error", error, 0);
    check("t4_busy", busy, 1);
    send_byte(8'h3C, 0);
    wait_idle();
    check("t4_done_n", done_n, 1);
    check("t4_hlt", core_HLT, 0);
    do_start(5'(MAX_LEN + 1), 1'b0);
    check("t4_len17_error", error, 1);
    check("t4_len17_busy", busy, 0);
    check("t4_len17_hlt", core_HLT, 0);

    // 5: slow host, stray start pulses, host_valid in IDLE
    clr();
    do_start(5'd2, 1'b0);
    check("t5_start_clears", error, 0);
    send_byte(8'hC3, 10);
    do_start(5'd5, 1'b1);
    repeat (3) @(negedge CLK);
    do_start(5'd7, 1'b1);
    send_byte(8'h3C, 10);
    wait_idle();
    check("t5_wd_n", wd_n, 2);
    check("t5_wd0", wd_log[0], 8'hC3);
    check("t5_wd1", wd_log[1], 8'h3C);
    check("t5_oe_n", oe_n, 0);
    check("t5_done_n", done_n, 1);
    check("t5_hr_bad", hr_bad, 0);
    wd_save = wd_n;
    host_data = 8'hFF; host_valid = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    check("t5_idle_ready", host_ready, 0);
    check("t5_idle_busy", busy, 0);
    check("t5_idle_wd", wd_n, wd_save);
    host_valid = 1'b0;

    // 6: async reset during the second WRITE go
    clr();
    do_start(5'd3, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (core_WE && core_go) begin ok = 1'b1; break; end
    end
    check("t6_saw_write_go", ok, 1);
    RESET = 1'b0;
    #1;
    check("t6_go", core_go, 0);
    check("t6_we", core_WE, 0);
    check("t6_load", core_load, 0);
    check("t6_hlt", core_HLT, 1);
    check("t6_busy", busy, 0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK); #1;
    clr();
    do_start(5'd2, 1'b1);
    send_byte(8'h9A, 0);
    send_byte(8'hBC, 0);
    wait_idle();
    check("t6_mar_n", mar_n, 4);
    check("t6_wd0", wd_log[0], 8'h9A);
    check("t6_wd1", wd_log[1], 8'hBC);
    check("t6_oe_n", oe_n, 2);
    check("t6_error", error, 0);
    check("t6_done_n", done_n, 1);
    check("t6_hlt", core_HLT, 0);

    // whole-run rules
    check("go_width", bad_go, 0);
    check("we_oe_load_exclusive", illegal, 0);
    check("ready_only_in_wait", hr_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
